// File: rtl/multi_channel_phase_accumulator.sv
// Multi-channel DDS phase accumulator: shadowed per-channel register file, linear
// frequency sweep with wrap/clamp, sync-based phase alignment and registered readback.

module mcpa_chan #(
  parameter int M = 48,
  parameter int N = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we_i,
  input  logic [2:0]   wr_addr_i,
  input  logic [M-1:0] wr_data_i,
  input  logic         update_i,
  input  logic         sync_i,
  input  logic [2:0]   rd_addr_i,
  output logic [M-1:0] rd_word_o,
  output logic [N-1:0] phase_o,
  output logic         evt_o
);

  localparam logic [2:0] A_FREQ  = 3'd0;
  localparam logic [2:0] A_OFF   = 3'd1;
  localparam logic [2:0] A_STEP  = 3'd2;
  localparam logic [2:0] A_LIM   = 3'd3;
  localparam logic [2:0] A_CTRL  = 3'd4;
  localparam logic [2:0] A_FREQA = 3'd5;
  localparam logic [2:0] A_ACC   = 3'd6;

  logic [M-1:0] freq_s_q, freq_s_d, off_s_q, off_s_d, step_s_q, step_s_d, lim_s_q, lim_s_d;
  logic [2:0]   ctrl_s_q, ctrl_s_d, ctrl_a_q, ctrl_a_d;
  logic [M-1:0] freq_a_q, freq_a_d, off_a_q, off_a_d, step_a_q, step_a_d, lim_a_q, lim_a_d;
  logic [M-1:0] start_q, start_d, acc_q, acc_d;
  logic         clamped_q, clamped_d, evt_q, evt_d;
  logic [N-1:0] phase_q, phase_d;

  logic         run, sweep_en, hold, step_neg, beyond, sweep_act;
  logic [M-1:0] step_mag, s_nxt, ph_sum;
  logic [M:0]   s_up, s_dn;

  assign run      = ctrl_a_q[0];
  assign sweep_en = ctrl_a_q[1];
  assign hold     = ctrl_a_q[2];
  assign step_neg = step_a_q[M-1];
  assign step_mag = step_neg ? (~step_a_q + M'(1)) : step_a_q;

  // One extra bit so overflow past 2^M and underflow below 0 are both visible.
  assign s_up   = {1'b0, freq_a_q} + {1'b0, step_mag};
  assign s_dn   = {1'b0, freq_a_q} - {1'b0, step_mag};
  assign beyond = step_neg ? (s_dn[M] || (s_dn < {1'b0, lim_a_q}))
                           : (s_up > {1'b0, lim_a_q});
  assign s_nxt  = step_neg ? s_dn[M-1:0] : s_up[M-1:0];

  assign sweep_act = run && sweep_en && !update_i && (step_a_q != '0);
  assign ph_sum    = acc_q + off_a_q;

  always_comb begin
    freq_s_d = freq_s_q;
    off_s_d  = off_s_q;
    step_s_d = step_s_q;
    lim_s_d  = lim_s_q;
    ctrl_s_d = ctrl_s_q;
    if (we_i) begin
      case (wr_addr_i)
        A_FREQ:  freq_s_d = wr_data_i;
        A_OFF:   off_s_d  = wr_data_i;
        A_STEP:  step_s_d = wr_data_i;
        A_LIM:   lim_s_d  = wr_data_i;
        A_CTRL:  ctrl_s_d = wr_data_i[2:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    freq_a_d  = freq_a_q;
    off_a_d   = off_a_q;
    step_a_d  = step_a_q;
    lim_a_d   = lim_a_q;
    ctrl_a_d  = ctrl_a_q;
    start_d   = start_q;
    clamped_d = clamped_q;
    evt_d     = 1'b0;
    if (update_i) begin
      freq_a_d  = freq_s_q;
      off_a_d   = off_s_q;
      step_a_d  = step_s_q;
      lim_a_d   = lim_s_q;
      ctrl_a_d  = ctrl_s_q;
      start_d   = freq_s_q;
      clamped_d = 1'b0;
    end else if (sweep_act) begin
      if (!beyond) begin
        freq_a_d = s_nxt;
      end else if (!hold) begin
        freq_a_d = start_q;
        evt_d    = 1'b1;
      end else begin
        // Clamp pulses once; afterwards the word just sits at the bound.
        freq_a_d  = lim_a_q;
        evt_d     = !clamped_q;
        clamped_d = 1'b1;
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (sync_i)   acc_d = '0;
    else if (run) acc_d = acc_q + freq_a_q;
    phase_d = ph_sum[M-1:M-N];
  end

  always_comb begin
    rd_word_o = '0;
    case (rd_addr_i)
      A_FREQ:  rd_word_o = freq_s_q;
      A_OFF:   rd_word_o = off_s_q;
      A_STEP:  rd_word_o = step_s_q;
      A_LIM:   rd_word_o = lim_s_q;
      A_CTRL:  rd_word_o = {{(M-3){1'b0}}, ctrl_s_q};
      A_FREQA: rd_word_o = freq_a_q;
      A_ACC:   rd_word_o = acc_q;
      default: rd_word_o = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      freq_s_q  <= '0;
      off_s_q   <= '0;
      step_s_q  <= '0;
      lim_s_q   <= '0;
      ctrl_s_q  <= '0;
      freq_a_q  <= '0;
      off_a_q   <= '0;
      step_a_q  <= '0;
      lim_a_q   <= '0;
      ctrl_a_q  <= '0;
      start_q   <= '0;
      acc_q     <= '0;
      clamped_q <= 1'b0;
      evt_q     <= 1'b0;
      phase_q   <= '0;
    end else begin
      freq_s_q  <= freq_s_d;
      off_s_q   <= off_s_d;
      step_s_q  <= step_s_d;
      lim_s_q   <= lim_s_d;
      ctrl_s_q  <= ctrl_s_d;
      freq_a_q  <= freq_a_d;
      off_a_q   <= off_a_d;
      step_a_q  <= step_a_d;
      lim_a_q   <= lim_a_d;
      ctrl_a_q  <= ctrl_a_d;
      start_q   <= start_d;
      acc_q     <= acc_d;
      clamped_q <= clamped_d;
      evt_q     <= evt_d;
      phase_q   <= phase_d;
    end
  end

  assign phase_o = phase_q;
  assign evt_o   = evt_q;

endmodule

module multi_channel_phase_accumulator #(
  parameter int M = 48,
  parameter int N = 14,
  parameter int C = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [3:0]     wr_ch,
  input  logic [2:0]     wr_addr,
  input  logic [M-1:0]   wr_data,
  input  logic           rd_en,
  input  logic [3:0]     rd_ch,
  input  logic [2:0]     rd_addr,
  output logic [M-1:0]   rd_data,
  output logic           rd_valid,
  input  logic           update,
  input  logic           sync,
  output logic [C*N-1:0] phase,
  output logic [C-1:0]   sweep_evt
);

  logic [C-1:0][M-1:0] rd_words;
  logic [C-1:0][N-1:0] ph;
  logic [C-1:0]        we;
  logic                wr_ok;
  logic [M-1:0]        rd_sel, rd_data_q, rd_data_d;
  logic                rd_valid_q;

  // Out-of-range channel or register writes are dropped entirely.
  assign wr_ok = wr_en && ({28'd0, wr_ch} < 32'(C)) && (wr_addr <= 3'd4);

  for (genvar k = 0; k < C; k++) begin : g_ch
    assign we[k] = wr_ok && (wr_ch == 4'(k));

    mcpa_chan #(.M(M), .N(N)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .we_i      (we[k]),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .update_i  (update),
      .sync_i    (sync),
      .rd_addr_i (rd_addr),
      .rd_word_o (rd_words[k]),
      .phase_o   (ph[k]),
      .evt_o     (sweep_evt[k])
    );

    assign phase[k*N +: N] = ph[k];
  end

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < C; k++) begin
      if (rd_ch == 4'(k)) rd_sel = rd_words[k];
    end
    rd_data_d = rd_en ? rd_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_multi_channel_phase_accumulator.sv
// Scoreboard bench: stimulus queues expected readbacks and per-cycle output values,
// a negedge monitor pops and compares them as the DUT presents them.

module tb_multi_channel_phase_accumulator;
  localparam int M = 16;
  localparam int N = 8;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           reset, wr_en, rd_en, update, sync;
  logic [3:0]     wr_ch, rd_ch;
  logic [2:0]     wr_addr, rd_addr;
  logic [M-1:0]   wr_data, rd_data;
  logic           rd_valid;
  logic [C*N-1:0] phase;
  logic [C-1:0]   sweep_evt;

  multi_channel_phase_accumulator #(.M(M), .N(N), .C(C)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .update(update), .sync(sync),
    .phase(phase), .sweep_evt(sweep_evt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int due; logic [M-1:0] exp; string name;} rd_t;
  typedef struct {int due; int kind; int ch; int val; string name;} ob_t;  // kind 0 phase, 1 evt, 2 rd_valid
  rd_t rd_q[$];
  ob_t ob_q[$];
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 0; rd_en = 0; update = 0; sync = 0;
  endtask

  task automatic set_wr(input int ch, input int a, input logic [M-1:0] d);
    wr_en = 1; wr_ch = 4'(ch); wr_addr = 3'(a); wr_data = d;
  endtask

  task automatic wr(input int ch, input int a, input logic [M-1:0] d);
    set_wr(ch, a, d);
    tick();
  endtask

  task automatic rd(input int ch, input int a, input logic [M-1:0] e, input string nm);
    rd_en = 1; rd_ch = 4'(ch); rd_addr = 3'(a);
    rd_q.push_back('{cyc + 1, e, nm});
  endtask

  task automatic ex(input int off, input int kind, input int ch, input int val, input string nm);
    ob_q.push_back('{cyc + off, kind, ch, val, nm});
  endtask

  always @(negedge clk) begin
    bit hit;
    logic [31:0] act;
    hit = 0;
    for (int i = rd_q.size() - 1; i >= 0; i--) begin
      if (rd_q[i].due <= cyc) begin
        checks++;
        if (rd_q[i].due < cyc || rd_valid !== 1'b1 || rd_data !== rd_q[i].exp) begin
          errors++;
          $display("FAIL %s: rd_valid=%b rd_data=%h, required rd_valid=1 rd_data=%h (cycle %0d)",
                   rd_q[i].name, rd_valid, rd_data, rd_q[i].exp, cyc);
        end
        if (rd_q[i].due == cyc) hit = 1;
        rd_q.delete(i);
      end
    end
    if (!hit && rd_valid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rd_valid: rd_valid=1 with no readback due (cycle %0d)", cyc);
    end
    for (int i = ob_q.size() - 1; i >= 0; i--) begin
      if (ob_q[i].due <= cyc) begin
        case (ob_q[i].kind)
          0:       act = 32'(phase[ob_q[i].ch*N +: N]);
          1:       act = 32'(sweep_evt[ob_q[i].ch]);
          default: act = 32'(rd_valid);
        endcase
        checks++;
        if (ob_q[i].due < cyc || act !== 32'(ob_q[i].val)) begin
          errors++;
          $display("FAIL %s ch%0d: got %h, required %h (cycle %0d)",
                   ob_q[i].name, ob_q[i].ch, act, ob_q[i].val, cyc);
        end
        ob_q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [M-1:0] f4[6];
    logic [M-1:0] f5[7];
    logic [M-1:0] f6[5];
    f4 = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0010, 16'h0020};
    f5 = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0040, 16'h0040, 16'h0040};
    f6 = '{16'h0100, 16'h00C0, 16'h0080, 16'h0100, 16'h00C0};

    reset = 1; wr_en = 0; wr_ch = 0; wr_addr = 0; wr_data = 0;
    rd_en = 0; rd_ch = 0; rd_addr = 0; update = 0; sync = 0;
    tick(); tick();
    ex(0, 0, 0, 0, "rst_phase"); ex(0, 0, 1, 0, "rst_phase");
    ex(0, 1, 0, 0, "rst_evt");   ex(0, 2, 0, 0, "rst_rd_valid");
    reset = 0;
    rd(0, 0, 16'h0000, "rst_freq_shadow");
    tick();

    // Basic accumulation on ch0, ch1 idle.
    wr(0, 0, 16'h0100);
    wr(0, 4, 16'h0001);
    update = 1; tick();
    ex(0, 0, 0, 0, "acc_phase0"); ex(0, 0, 1, 0, "acc_phase1");
    for (int j = 1; j <= 5; j++) begin
      ex(j, 0, 0, j - 1, "acc_phase0");
      ex(j, 0, 1, 0, "acc_phase1");
    end
    for (int j = 1; j <= 5; j++) begin
      if (j == 3) rd(0, 6, 16'h0200, "acc_readback");
      if (j == 4) rd(0, 5, 16'h0100, "acc_freq_a");
      tick();
    end

    // Half-scale frequency wraps every other cycle.
    wr(0, 0, 16'h8000);
    sync = 1; update = 1; tick();
    for (int j = 1; j <= 4; j++) ex(j, 0, 0, (j % 2 == 0) ? 8'h80 : 8'h00, "wrap_phase0");
    for (int j = 0; j < 4; j++) begin
      if (j == 0) rd(0, 6, 16'h0000, "wrap_acc_after_sync");
      if (j == 1) rd(0, 6, 16'h8000, "wrap_acc_half");
      tick();
    end

    // Phase offset after sync alignment.
    wr(0, 0, 16'h0300);
    wr(1, 0, 16'h0300);
    wr(1, 4, 16'h0001);
    wr(0, 1, 16'h4000);
    sync = 1; update = 1; tick();
    for (int j = 1; j <= 4; j++) begin
      ex(j, 0, 0, 8'h40 + 3 * (j - 1), "offset_phase0");
      ex(j, 0, 1, 3 * (j - 1), "offset_phase1");
    end
    repeat (4) tick();

    // Up-sweep, wrap mode.
    wr(1, 0, 16'h0010);
    wr(1, 2, 16'h0010);
    wr(1, 3, 16'h0040);
    wr(1, 4, 16'h0003);
    update = 1; tick();
    for (int j = 1; j <= 5; j++) ex(j, 1, 1, (j == 4) ? 1 : 0, "sweep_wrap_evt");
    for (int j = 0; j < 6; j++) begin
      rd(1, 5, f4[j], "sweep_wrap_freq");
      tick();
    end

    // Up-sweep, clamp mode: sticks at the limit with a single pulse.
    wr(1, 4, 16'h0007);
    update = 1; tick();
    for (int j = 1; j <= 7; j++) ex(j, 1, 1, (j == 4) ? 1 : 0, "sweep_clamp_evt");
    for (int j = 0; j < 7; j++) begin
      rd(1, 5, f5[j], "sweep_clamp_freq");
      tick();
    end

    // Down-sweep on ch0 with a negative step.
    wr(0, 0, 16'h0100);
    wr(0, 2, 16'hFFC0);
    wr(0, 3, 16'h0080);
    wr(0, 4, 16'h0003);
    update = 1; tick();
    for (int j = 1; j <= 4; j++) ex(j, 1, 0, (j == 3) ? 1 : 0, "sweep_down_evt");
    for (int j = 0; j < 5; j++) begin
      rd(0, 5, f6[j], "sweep_down_freq");
      tick();
    end

    // Write racing update, ignored writes and readback edges.
    wr(0, 4, 16'h0001);
    wr(0, 0, 16'h0300);
    update = 1; tick();
    set_wr(0, 0, 16'h1234); update = 1; tick();
    rd(0, 5, 16'h0300, "race_freq_a_old"); tick();
    rd(0, 0, 16'h1234, "race_shadow_new"); tick();
    wr(3, 0, 16'hFFFF);
    wr(0, 5, 16'hBEEF);
    wr(0, 7, 16'hBEEF);
    rd(0, 5, 16'h0300, "ignored_freq_a");   tick();
    rd(0, 1, 16'h4000, "ignored_offset");   tick();
    rd(1, 0, 16'h0010, "ignored_ch_alias"); tick();
    rd(0, 0, 16'h1234, "ignored_freq");     tick();
    rd(1, 4, 16'h0007, "rd_ctrl");          tick();
    rd(0, 2, 16'hFFC0, "rd_step");          tick();
    rd(1, 7, 16'h0000, "rd_addr7");         tick();
    rd(2, 0, 16'h0000, "rd_ch_oob");        tick();

    // Reset mid-sweep, overriding every other strobe.
    reset = 1; sync = 1; update = 1; set_wr(0, 0, 16'h5555);
    rd_en = 1; rd_ch = 0; rd_addr = 0;
    tick();
    ex(0, 0, 0, 0, "rst2_phase"); ex(0, 0, 1, 0, "rst2_phase");
    ex(0, 1, 0, 0, "rst2_evt");   ex(0, 1, 1, 0, "rst2_evt");
    ex(0, 2, 0, 0, "rst2_rd_valid");
    reset = 0;
    for (int ch = 0; ch < C; ch++) begin
      for (int a = 0; a < 7; a++) begin
        rd(ch, a, 16'h0000, "rst2_reg");
        tick();
      end
    end
    ex(0, 0, 0, 0, "rst2_phase_idle"); ex(0, 0, 1, 0, "rst2_phase_idle");
    repeat (3) tick();

    if (rd_q.size() != 0 || ob_q.size() != 0) begin
      checks += rd_q.size() + ob_q.size();
      errors += rd_q.size() + ob_q.size();
      $display("FAIL leftover: %0d expectations never checked, required 0", rd_q.size() + ob_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
